// File: rtl/inc_pipe_mc.sv
// ---------------------------------------------------------------------------
// inc_pipe_mc
//
// Multi-lane registered incrementer with valid/ready flow control.
// Every lane of an accepted transfer gets INC added independently (no carry
// between lanes). The result, plus a per-lane carry-out flag, is held in a
// single output register stage until the sink takes it. A free-running
// counter tallies completed output handshakes.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   reset      : synchronous, active-high; clears out_valid/out_data/out_ovf/
//                txn_count and discards any input presented at the same edge
//   in_valid   : source presents a transfer
//   in_ready   : block can accept this cycle (= !out_valid || out_ready)
//   in_data    : NCH lanes, lane i at [i*WIDTH +: WIDTH]
//   out_valid  : output register holds a transfer
//   out_ready  : sink accepts the held transfer this cycle
//   out_data   : incremented lanes, same packing as in_data
//   out_ovf    : bit i set when lane i carried out of WIDTH bits
//   txn_count  : completed output handshakes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module inc_pipe_mc #(
    parameter int          NCH   = 3,
    parameter int          WIDTH = 40,
    parameter int unsigned INC   = 1,
    parameter int          SAT   = 0,
    parameter int          CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH-1:0]         out_ovf,
    output logic [CNT_W-1:0]       txn_count
);

    // Elaboration-time sanity checks on the geometry parameters.
    if (NCH < 1) begin : g_chk_nch
        $error("inc_pipe_mc: NCH must be >= 1");
    end
    if (WIDTH < 1) begin : g_chk_width
        $error("inc_pipe_mc: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("inc_pipe_mc: CNT_W must be >= 1");
    end

    // Increment truncated to the lane width (an oversized INC wraps).
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic                 out_valid_reg;
    logic [NCH*WIDTH-1:0] out_data_reg;
    logic [NCH-1:0]       out_ovf_reg;
    logic [CNT_W-1:0]     txn_count_reg;

    logic [NCH*WIDTH-1:0] data_next;
    logic [NCH-1:0]       ovf_next;

    logic accept;
    logic xfer;

    // in_ready depends only on the held state and out_ready, never on
    // in_valid, so a source may legally wait for in_ready before asserting.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_reg && out_ready;

    // Per-lane adders: one extra bit captures the carry-out for the flag
    // and, in saturating mode, selects the all-ones clamp.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
        logic [WIDTH:0] sum;

        assign sum          = {1'b0, in_data[gi*WIDTH +: WIDTH]} + {1'b0, INC_W};
        assign ovf_next[gi] = sum[WIDTH];

        if (SAT != 0) begin : g_sat
            assign data_next[gi*WIDTH +: WIDTH] = sum[WIDTH] ? {WIDTH{1'b1}}
                                                             : sum[WIDTH-1:0];
        end else begin : g_wrap
            assign data_next[gi*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        end
    end

    // Output register stage. An accept takes priority over a plain transfer,
    // which lets a simultaneous drain-and-refill keep out_valid high and
    // sustain one transfer per cycle. Without an accept the data and flags
    // are left untouched so they stay bit-stable during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ovf_reg   <= '0;
            txn_count_reg <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= data_next;
                out_ovf_reg   <= ovf_next;
            end else if (xfer) begin
                out_valid_reg <= 1'b0;
            end

            if (xfer) begin
                txn_count_reg <= txn_count_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_inc_pipe_mc.sv
// ---------------------------------------------------------------------------
// tb_inc_pipe_mc
//
// Two instances share one stimulus stream: dut_a wraps (SAT=0, CNT_W=16),
// dut_b saturates with a 4-bit transfer counter (SAT=1, CNT_W=4).
// A transaction-level reference model follows the handshakes at every
// falling edge; directed tables and sequences cover the listed corner cases,
// then a randomized phase with occasional resets runs against the model.
// ---------------------------------------------------------------------------
module tb_inc_pipe_mc;

    localparam int NCH = 3;
    localparam int W   = 40;
    localparam int INC = 1;
    localparam int DW  = NCH * W;
    localparam longint unsigned LANE_MAX = 64'h0000_00FF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [NCH-1:0] out_ovf_a, out_ovf_b;
    logic [15:0]   txn_count_a;
    logic [3:0]    txn_count_b;

    always #5 clk = ~clk;

    inc_pipe_mc #(.NCH(NCH), .WIDTH(W), .INC(INC), .SAT(0), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ovf(out_ovf_a), .txn_count(txn_count_a)
    );

    inc_pipe_mc #(.NCH(NCH), .WIDTH(W), .INC(INC), .SAT(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(out_ovf_b), .txn_count(txn_count_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer add per lane, then wrap by modulo
    // or clamp to the lane maximum.
    function automatic void model_calc(input logic [DW-1:0] din,
                                       output logic [DW-1:0] wrap_o,
                                       output logic [DW-1:0] sat_o,
                                       output logic [NCH-1:0] ovf_o);
        longint unsigned v, s;
        wrap_o = '0;
        sat_o  = '0;
        ovf_o  = '0;
        for (int i = 0; i < NCH; i++) begin
            v = 64'(din[i*W +: W]);
            s = v + 64'(INC);
            ovf_o[i]         = (s > LANE_MAX);
            wrap_o[i*W +: W] = W'(s % (LANE_MAX + 64'd1));
            sat_o[i*W +: W]  = W'((s > LANE_MAX) ? LANE_MAX : s);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        logic [63:0]   r;
        d = '0;
        for (int i = 0; i < NCH; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       d[i*W +: W] = '1;
                1:       d[i*W +: W] = 40'hFF_FFFF_FFFE;
                default: d[i*W +: W] = r[W-1:0];
            endcase
        end
        return d;
    endfunction

    // ---------------- reference model (checked every falling edge) --------
    bit             live = 1'b0;
    bit             m_valid = 1'b0;
    logic [DW-1:0]  m_data_a = '0, m_data_b = '0;
    logic [NCH-1:0] m_ovf = '0;
    int             m_cnt = 0;

    always @(negedge clk) begin
        logic [DW-1:0]  wa, sb;
        logic [NCH-1:0] ov;
        bit             m_xfer, m_acc;
        if (live) begin
            chk("mdl_valid_a", 128'(out_valid_a), 128'(m_valid));
            chk("mdl_valid_b", 128'(out_valid_b), 128'(m_valid));
            chk("mdl_ready_a", 128'(in_ready_a), 128'(!m_valid || out_ready));
            chk("mdl_ready_b", 128'(in_ready_b), 128'(!m_valid || out_ready));
            chk("mdl_data_a", 128'(out_data_a), 128'(m_data_a));
            chk("mdl_data_b", 128'(out_data_b), 128'(m_data_b));
            chk("mdl_ovf_a", 128'(out_ovf_a), 128'(m_ovf));
            chk("mdl_ovf_b", 128'(out_ovf_b), 128'(m_ovf));
            chk("mdl_cnt_a", 128'(txn_count_a), 128'(m_cnt % 65536));
            chk("mdl_cnt_b", 128'(txn_count_b), 128'(m_cnt % 16));
        end
        if (reset) begin
            live     = 1'b1;
            m_valid  = 1'b0;
            m_data_a = '0;
            m_data_b = '0;
            m_ovf    = '0;
            m_cnt    = 0;
        end else if (live) begin
            m_xfer = m_valid && out_ready;
            m_acc  = in_valid && (!m_valid || out_ready);
            if (m_xfer) m_cnt++;
            if (m_acc) begin
                model_calc(in_data, wa, sb, ov);
                m_data_a = wa;
                m_data_b = sb;
                m_ovf    = ov;
                m_valid  = 1'b1;
            end else if (m_xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [DW-1:0]  din;
        logic [DW-1:0]  exp_wrap;
        logic [DW-1:0]  exp_sat;
        logic [NCH-1:0] exp_ovf;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int c0;

        tbl[0].din      = {40'h00_0000_0000, 40'h12_3456_789A, 40'h00_0000_0005};
        tbl[0].exp_wrap = {40'h00_0000_0001, 40'h12_3456_789B, 40'h00_0000_0006};
        tbl[0].exp_sat  = {40'h00_0000_0001, 40'h12_3456_789B, 40'h00_0000_0006};
        tbl[0].exp_ovf  = 3'b000;
        tbl[1].din      = {40'h7F_FFFF_FFFF, 40'h00_0000_0007, 40'hFF_FFFF_FFFF};
        tbl[1].exp_wrap = {40'h80_0000_0000, 40'h00_0000_0008, 40'h00_0000_0000};
        tbl[1].exp_sat  = {40'h80_0000_0000, 40'h00_0000_0008, 40'hFF_FFFF_FFFF};
        tbl[1].exp_ovf  = 3'b001;
        tbl[2].din      = {40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 40'h00_0000_0000};
        tbl[2].exp_wrap = {40'h00_0000_0000, 40'h00_0000_0000, 40'h00_0000_0001};
        tbl[2].exp_sat  = {40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 40'h00_0000_0001};
        tbl[2].exp_ovf  = 3'b110;
        tbl[3].din      = {40'h00_0000_0001, 40'hAB_CDEF_0123, 40'hFF_FFFF_FFFE};
        tbl[3].exp_wrap = {40'h00_0000_0002, 40'hAB_CDEF_0124, 40'hFF_FFFF_FFFF};
        tbl[3].exp_sat  = {40'h00_0000_0002, 40'hAB_CDEF_0124, 40'hFF_FFFF_FFFF};
        tbl[3].exp_ovf  = 3'b000;

        // Reset held 3 cycles with input offered: nothing may get through.
        in_valid = 1'b1;
        in_data  = rand_data();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_valid", 128'(out_valid_a), 128'(0));
            chk("rst_cnt", 128'(txn_count_a), 128'(0));
            chk("rst_data", 128'(out_data_a), 128'(0));
        end
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready_a), 128'(1));
        chk("post_rst_valid", 128'(out_valid_a), 128'(0));
        @(posedge clk); #1;

        // Table vectors, one transfer each, sink always ready.
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_data   = tbl[k].din;
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            $display("vec %0d: in=%h out_a=%h out_b=%h ovf=%b", k,
                     tbl[k].din, out_data_a, out_data_b, out_ovf_a);
            chk("tbl_valid", 128'(out_valid_a), 128'(1));
            chk("tbl_data_wrap", 128'(out_data_a), 128'(tbl[k].exp_wrap));
            chk("tbl_data_sat", 128'(out_data_b), 128'(tbl[k].exp_sat));
            chk("tbl_ovf_wrap", 128'(out_ovf_a), 128'(tbl[k].exp_ovf));
            chk("tbl_ovf_sat", 128'(out_ovf_b), 128'(tbl[k].exp_ovf));
            chk("tbl_cnt", 128'(txn_count_a), 128'(k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tbl_cnt_final", 128'(txn_count_a), 128'(4));
        @(posedge clk); #1;

        // Backpressure: lane0=7 held for 5 stalled cycles, second offer waits.
        c0        = 4;
        in_valid  = 1'b1;
        in_data   = {80'h0, 40'd7};
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = {80'h0, 40'd100};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            $display("stall %0d: out_valid=%b lane0=%0d in_ready=%b", k,
                     out_valid_a, out_data_a[W-1:0], in_ready_a);
            chk("stall_valid", 128'(out_valid_a), 128'(1));
            chk("stall_lane0", 128'(out_data_a[W-1:0]), 128'(8));
            chk("stall_in_ready", 128'(in_ready_a), 128'(0));
            chk("stall_cnt", 128'(txn_count_a), 128'(c0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 128'(in_ready_a), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("second_valid", 128'(out_valid_a), 128'(1));
        chk("second_lane0", 128'(out_data_a[W-1:0]), 128'(101));
        chk("second_cnt", 128'(txn_count_a), 128'(c0 + 1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_valid", 128'(out_valid_a), 128'(0));
        chk("drain_cnt", 128'(txn_count_a), 128'(c0 + 2));
        @(posedge clk); #1;

        // Streaming: 100 back-to-back transfers from a clean counter.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            in_valid  = 1'b1;
            in_data   = rand_data();
            out_ready = 1'b1;
            @(negedge clk);
            if (k > 0) chk("stream_no_bubble", 128'(out_valid_a), 128'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", 128'(out_valid_a), 128'(1));
        chk("stream_cnt_99", 128'(txn_count_a), 128'(99));
        @(posedge clk); #1;
        @(negedge clk);
        $display("stream: txn_count_a=%0d txn_count_b=%0d", txn_count_a, txn_count_b);
        chk("stream_cnt_a", 128'(txn_count_a), 128'(100));
        chk("stream_cnt_b", 128'(txn_count_b), 128'(100 % 16));
        @(posedge clk); #1;

        // Reset while a transfer is stalled: it is dropped, never counted.
        in_valid  = 1'b1;
        in_data   = rand_data();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_held", 128'(out_valid_a), 128'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 128'(out_valid_a), 128'(0));
        chk("midrst_cnt", 128'(txn_count_a), 128'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("midrst_never_delivered", 128'(out_valid_a), 128'(0));
            chk("midrst_cnt_hold", 128'(txn_count_a), 128'(0));
        end
        @(posedge clk); #1;

        // Counter wrap on the 4-bit instance: 17 transfers leave it at 1.
        for (int k = 0; k < 17; k++) begin
            in_valid  = 1'b1;
            in_data   = rand_data();
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        $display("wrap: txn_count_a=%0d txn_count_b=%0d", txn_count_a, txn_count_b);
        chk("wrap_cnt_b", 128'(txn_count_b), 128'(1));
        chk("wrap_cnt_a", 128'(txn_count_a), 128'(17));
        @(posedge clk); #1;

        // Randomized traffic with occasional resets, checked by the model.
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_data   = rand_data();
            @(posedge clk); #1;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
